// File: rtl/object_reporter_pkg.sv
// Shared widths, table-word field layout and FSM state encoding for the
// object reporter and the labeler that fills its data table.
package object_reporter_pkg;

  localparam int DEF_WORD_SIZE = 8;
  localparam int DEF_LOC_SIZE  = 8;
  localparam int DEF_OBJ_WIDTH = 16;
  localparam int D_WIDTH       = 3 * DEF_OBJ_WIDTH;

  // Table word is {ysum, xsum, area}; field index times OBJ_WIDTH gives the LSB.
  localparam int AREA_FIELD = 0;
  localparam int XSUM_FIELD = 1;
  localparam int YSUM_FIELD = 2;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ADDR  = 3'd1,
    S_FETCH = 3'd2,
    S_DIV   = 3'd3,
    S_OUT   = 3'd4,
    S_FIN   = 3'd5
  } state_t;

endpackage

// File: rtl/object_reporter_if.sv
// Table read port and record output channel of the object reporter.
interface object_reporter_if
  import object_reporter_pkg::*;
#(
  parameter int WORD_SIZE = DEF_WORD_SIZE,
  parameter int LOC_SIZE  = DEF_LOC_SIZE,
  parameter int OBJ_WIDTH = DEF_OBJ_WIDTH
);

  logic [WORD_SIZE-1:0]   obj_id;
  logic [3*OBJ_WIDTH-1:0] obj_data;

  // Record channel: a record transfers on every rising edge where out_valid and
  // out_ready are both high; while out_valid is high and out_ready low, every
  // out_* field is held unchanged and out_valid stays high.
  logic                   out_valid;
  logic                   out_ready;
  logic [WORD_SIZE-1:0]   out_id;
  logic [OBJ_WIDTH-1:0]   out_area;
  logic [LOC_SIZE-1:0]    out_x;
  logic [LOC_SIZE-1:0]    out_y;

  modport master (
    output obj_id,
    input  obj_data,
    output out_valid,
    input  out_ready,
    output out_id,
    output out_area,
    output out_x,
    output out_y
  );

  modport slave (
    input  obj_id,
    output obj_data,
    input  out_valid,
    output out_ready,
    input  out_id,
    input  out_area,
    input  out_x,
    input  out_y
  );

endinterface

// File: rtl/object_reporter_seq_divider.sv
// Unsigned restoring divider, one quotient bit per cycle; done is high during the
// final iteration so the quotient register is complete on the following cycle.
module seq_divider #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] quotient,
  output logic         done
);

  localparam int CW = $clog2(W + 1);

  logic [W-1:0]  rem_q, rem_d;
  logic [W-1:0]  quo_q, quo_d;
  logic [W-1:0]  dvs_q, dvs_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          run_q, run_d;
  logic [W:0]    shifted;
  logic [W:0]    diff;

  always_comb begin
    shifted = {rem_q, quo_q[W-1]};
    diff    = shifted - {1'b0, dvs_q};
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    cnt_d   = cnt_q;
    run_d   = run_q;
    if (start) begin
      rem_d = '0;
      quo_d = dividend;
      dvs_d = divisor;
      cnt_d = '0;
      run_d = 1'b1;
    end else if (run_q) begin
      // A clear top bit of diff means the trial subtraction did not borrow.
      if (!diff[W]) begin
        rem_d = diff[W-1:0];
        quo_d = {quo_q[W-2:0], 1'b1};
      end else begin
        rem_d = shifted[W-1:0];
        quo_d = {quo_q[W-2:0], 1'b0};
      end
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == CW'(W - 1)) run_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
      cnt_q <= '0;
      run_q <= 1'b0;
    end else begin
      rem_q <= rem_d;
      quo_q <= quo_d;
      dvs_q <= dvs_d;
      cnt_q <= cnt_d;
      run_q <= run_d;
    end
  end

  assign quotient = quo_q;
  assign done     = run_q && (cnt_q == CW'(W - 1));

endmodule

// File: rtl/object_reporter.sv
// Scans the per-label accumulator table at end of frame and emits one
// {id, area, centroid} record per object whose area reaches MIN_AREA.
module object_reporter
  import object_reporter_pkg::*;
#(
  parameter int WORD_SIZE = DEF_WORD_SIZE,
  parameter int LOC_SIZE  = DEF_LOC_SIZE,
  parameter int OBJ_WIDTH = DEF_OBJ_WIDTH,
  parameter int MIN_AREA  = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [WORD_SIZE-1:0] num_labels,
  object_reporter_if.master    bus,
  output logic                 busy,
  output logic                 done,
  output state_t               dbg_state
);

  localparam int AREA_LSB = AREA_FIELD * OBJ_WIDTH;
  localparam int XSUM_LSB = XSUM_FIELD * OBJ_WIDTH;
  localparam int YSUM_LSB = YSUM_FIELD * OBJ_WIDTH;

  state_t               state_q, state_d;
  logic [WORD_SIZE-1:0] id_q, id_d;
  logic [WORD_SIZE-1:0] limit_q, limit_d;
  logic [WORD_SIZE-1:0] out_id_q, out_id_d;
  logic [OBJ_WIDTH-1:0] out_area_q, out_area_d;
  logic                 done_q;

  logic [OBJ_WIDTH-1:0] area;
  logic [OBJ_WIDTH-1:0] xsum;
  logic [OBJ_WIDTH-1:0] ysum;
  logic                 skip;
  logic                 last_id;
  logic                 div_start;
  logic [OBJ_WIDTH-1:0] x_quo;
  logic [OBJ_WIDTH-1:0] y_quo;
  logic                 x_done;
  logic                 y_done;

  assign area    = bus.obj_data[AREA_LSB +: OBJ_WIDTH];
  assign xsum    = bus.obj_data[XSUM_LSB +: OBJ_WIDTH];
  assign ysum    = bus.obj_data[YSUM_LSB +: OBJ_WIDTH];
  assign skip    = (area == '0) || (area < OBJ_WIDTH'(MIN_AREA));
  assign last_id = (id_q == limit_q - 1'b1);

  always_comb begin
    state_d    = state_q;
    id_d       = id_q;
    limit_d    = limit_q;
    out_id_d   = out_id_q;
    out_area_d = out_area_q;
    div_start  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          limit_d = num_labels;
          id_d    = WORD_SIZE'(1);
          // Label 0 is reserved, so fewer than two labels means an empty table.
          state_d = (num_labels < WORD_SIZE'(2)) ? S_FIN : S_ADDR;
        end
      end
      S_ADDR:  state_d = S_FETCH;
      S_FETCH: begin
        if (skip) begin
          if (last_id) begin
            state_d = S_FIN;
          end else begin
            id_d    = id_q + 1'b1;
            state_d = S_ADDR;
          end
        end else begin
          out_id_d   = id_q;
          out_area_d = area;
          div_start  = 1'b1;
          state_d    = S_DIV;
        end
      end
      S_DIV: begin
        if (x_done && y_done) state_d = S_OUT;
      end
      S_OUT: begin
        if (bus.out_ready) begin
          if (last_id) begin
            state_d = S_FIN;
          end else begin
            id_d    = id_q + 1'b1;
            state_d = S_ADDR;
          end
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      id_q       <= '0;
      limit_q    <= '0;
      out_id_q   <= '0;
      out_area_q <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      id_q       <= id_d;
      limit_q    <= limit_d;
      out_id_q   <= out_id_d;
      out_area_q <= out_area_d;
      done_q     <= (state_q == S_FIN);
    end
  end

  seq_divider #(.W(OBJ_WIDTH)) u_div_x (
    .clk      (clk),
    .reset    (reset),
    .start    (div_start),
    .dividend (xsum),
    .divisor  (area),
    .quotient (x_quo),
    .done     (x_done)
  );

  seq_divider #(.W(OBJ_WIDTH)) u_div_y (
    .clk      (clk),
    .reset    (reset),
    .start    (div_start),
    .dividend (ysum),
    .divisor  (area),
    .quotient (y_quo),
    .done     (y_done)
  );

  // Quotient registers hold their value while idle, which keeps out_x/out_y
  // stable for the whole OUT stall without extra capture registers.
  logic unused_quo_hi;
  assign unused_quo_hi = ^{x_quo[OBJ_WIDTH-1:LOC_SIZE], y_quo[OBJ_WIDTH-1:LOC_SIZE]};

  assign bus.obj_id    = id_q;
  assign bus.out_valid = (state_q == S_OUT);
  assign bus.out_id    = out_id_q;
  assign bus.out_area  = out_area_q;
  assign bus.out_x     = x_quo[LOC_SIZE-1:0];
  assign bus.out_y     = y_quo[LOC_SIZE-1:0];
  assign busy          = (state_q != S_IDLE);
  assign done          = done_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_object_reporter.sv
// Directed bench for object_reporter: a registered table model, a record
// scoreboard with an expected queue, and a negedge monitor.
module tb_object_reporter;
  import object_reporter_pkg::*;

  localparam int WS = DEF_WORD_SIZE;
  localparam int LS = DEF_LOC_SIZE;
  localparam int OW = DEF_OBJ_WIDTH;
  localparam int RW = WS + OW + 2 * LS;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [WS-1:0] num_labels;
  logic          busy;
  logic          done;
  state_t        dbg_state;

  object_reporter_if bus ();

  object_reporter #(.MIN_AREA(1)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .num_labels (num_labels),
    .bus        (bus),
    .busy       (busy),
    .done       (done),
    .dbg_state  (dbg_state)
  );

  // ---------------- clock / table model ----------------
  always #5 clk = ~clk;

  logic [3*OW-1:0] mem [0:255];
  always @(posedge clk) bus.obj_data <= mem[bus.obj_id];

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  int hs_cnt = 0;
  int done_cnt = 0;
  logic [RW-1:0] exp_q[$];

  function automatic logic [3*OW-1:0] mk_word(input int ysum, input int xsum, input int area);
    logic [OW-1:0] y, x, a;
    y = OW'(ysum);
    x = OW'(xsum);
    a = OW'(area);
    return {y, x, a};
  endfunction

  function automatic logic [RW-1:0] mk_rec(input int id, input int area, input int x, input int y);
    logic [WS-1:0] i;
    logic [OW-1:0] a;
    logic [LS-1:0] xx, yy;
    i = WS'(id);
    a = OW'(area);
    xx = LS'(x);
    yy = LS'(y);
    return {i, a, xx, yy};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
    end
  endtask

  // ---------------- monitor ----------------
  logic          held = 1'b0;
  logic [RW-1:0] snap;
  logic [RW-1:0] cur;
  logic [RW-1:0] exp_rec;

  always @(negedge clk) begin
    if (reset) begin
      held = 1'b0;
    end else begin
      if (done) done_cnt++;
      cur = {bus.out_id, bus.out_area, bus.out_x, bus.out_y};
      if (bus.out_valid) begin
        if (held) check("stall_fields", 64'(cur), 64'(snap));
        if (bus.out_ready) begin
          hs_cnt++;
          held = 1'b0;
          if (exp_q.size() == 0) begin
            check("unexpected_record", 64'(cur), 64'(0) - 64'd1);
          end else begin
            exp_rec = exp_q.pop_front();
            check("record", 64'(cur), 64'(exp_rec));
          end
        end else begin
          held = 1'b1;
          snap = cur;
        end
      end else begin
        if (held) check("stall_valid", 64'(bus.out_valid), 64'd1);
        held = 1'b0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int max_cycles, input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < max_cycles && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    check(name, 64'(seen), 64'd1);
  endtask

  // ---------------- stimulus ----------------
  int  d0, h0, lat;
  bit  seen_v;

  initial begin
    reset = 1'b1;
    start = 1'b0;
    num_labels = '0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 256; i++) mem[i] = '0;
    repeat (3) tick();
    reset = 1'b0;

    // Reset state
    @(negedge clk);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_valid", 64'(bus.out_valid), 64'd0);
    check("reset_obj_id", 64'(bus.obj_id), 64'd0);
    check("reset_fields", 64'({bus.out_id, bus.out_area, bus.out_x, bus.out_y}), 64'd0);
    check("reset_state", 64'(dbg_state), 64'(S_IDLE));

    // Single object, latency and done pulse
    mem[1] = mk_word(40, 20, 4);
    num_labels = 8'd2;
    exp_q.push_back(mk_rec(1, 4, 5, 10));
    d0 = done_cnt;
    h0 = hs_cnt;
    pulse_start();
    seen_v = 1'b0;
    lat = 0;
    for (int i = 1; i <= 40 && !seen_v; i++) begin
      @(negedge clk);
      if (i == 1) check("t1_busy", 64'(busy), 64'd1);
      if (bus.out_valid) begin
        seen_v = 1'b1;
        lat = i;
      end
    end
    check("t1_latency", 64'(lat), 64'd19);
    wait_done(20, "t1_done");
    tick();
    check("t1_done_count", 64'(done_cnt - d0), 64'd1);
    check("t1_records", 64'(hs_cnt - h0), 64'd1);
    check("t1_busy_after", 64'(busy), 64'd0);

    // Empty table: done two cycles after start, no records
    num_labels = 8'd1;
    h0 = hs_cnt;
    pulse_start();
    @(negedge clk);
    check("t2_done_n1", 64'(done), 64'd0);
    check("t2_busy_n1", 64'(busy), 64'd1);
    @(negedge clk);
    check("t2_done_n2", 64'(done), 64'd1);
    check("t2_busy_n2", 64'(busy), 64'd0);
    @(negedge clk);
    check("t2_done_n3", 64'(done), 64'd0);
    check("t2_records", 64'(hs_cnt - h0), 64'd0);

    // Zero-area skip and truncation
    mem[1] = mk_word(7, 9, 0);
    mem[2] = mk_word(20, 10, 3);
    mem[3] = mk_word(9, 7, 2);
    num_labels = 8'd4;
    exp_q.push_back(mk_rec(2, 3, 3, 6));
    exp_q.push_back(mk_rec(3, 2, 3, 4));
    h0 = hs_cnt;
    pulse_start();
    wait_done(200, "t3_done");
    tick();
    check("t3_records", 64'(hs_cnt - h0), 64'd2);

    // Back-pressure: 20-cycle stall in OUT
    mem[1] = mk_word(100, 50, 7);
    num_labels = 8'd2;
    bus.out_ready = 1'b0;
    exp_q.push_back(mk_rec(1, 7, 7, 14));
    h0 = hs_cnt;
    pulse_start();
    seen_v = 1'b0;
    for (int i = 0; i < 40 && !seen_v; i++) begin
      @(negedge clk);
      if (bus.out_valid) seen_v = 1'b1;
    end
    check("t4_valid_seen", 64'(seen_v), 64'd1);
    repeat (20) @(negedge clk);
    check("t4_no_early_record", 64'(hs_cnt - h0), 64'd0);
    tick();
    bus.out_ready = 1'b1;
    wait_done(20, "t4_done");
    tick();
    check("t4_records", 64'(hs_cnt - h0), 64'd1);

    // Wide quotients, latched limit, ignored second start
    mem[1] = mk_word(300, 1000, 1);
    mem[2] = mk_word(65535, 65535, 65535);
    mem[3] = mk_word(12345, 999, 100);
    mem[4] = mk_word(4, 4, 1);
    num_labels = 8'd4;
    exp_q.push_back(mk_rec(1, 1, 232, 44));
    exp_q.push_back(mk_rec(2, 65535, 1, 1));
    exp_q.push_back(mk_rec(3, 100, 9, 123));
    d0 = done_cnt;
    h0 = hs_cnt;
    pulse_start();
    repeat (10) tick();
    num_labels = 8'd10;
    pulse_start();
    wait_done(300, "t5_done");
    repeat (4) tick();
    check("t5_records", 64'(hs_cnt - h0), 64'd3);
    check("t5_done_count", 64'(done_cnt - d0), 64'd1);
    check("t5_idle", 64'(busy), 64'd0);

    // Reset during DIV aborts, then a fresh scan completes
    mem[1] = mk_word(40, 20, 4);
    num_labels = 8'd2;
    d0 = done_cnt;
    h0 = hs_cnt;
    pulse_start();
    repeat (3) tick();
    check("t6_in_div", 64'(dbg_state), 64'(S_DIV));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    check("t6_busy", 64'(busy), 64'd0);
    check("t6_valid", 64'(bus.out_valid), 64'd0);
    check("t6_fields", 64'({bus.out_id, bus.out_area, bus.out_x, bus.out_y}), 64'd0);
    repeat (25) @(negedge clk);
    check("t6_no_done", 64'(done_cnt - d0), 64'd0);
    check("t6_no_record", 64'(hs_cnt - h0), 64'd0);
    exp_q.push_back(mk_rec(1, 4, 5, 10));
    pulse_start();
    wait_done(60, "t6_done");
    tick();
    check("t6_records", 64'(hs_cnt - h0), 64'd1);

    repeat (5) tick();
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
